mem_line_responder: RTL and testbench

//  Synthesizable memory-side responder for the core_l1d_l1i memory port; serves 128-bit

---
 rtl/mem_rsp_pkg.sv | 13 +
 rtl/mem_line_responder_if.sv | 21 ++
 rtl/mem_rsp_ram.sv | 23 ++
 rtl/mem_line_responder.sv | 146 ++++++++++++++
 tb/tb_mem_line_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the memory-side line responder.
package mem_rsp_pkg;
  localparam int         LINE_W      = 128;
  localparam int         CNT_W       = 9;
  localparam logic [3:0] MEM_LD_LINE = 4'd4;
  localparam logic [3:0] MEM_ST_LINE = 4'd7;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == MEM_LD_LINE) || (op == MEM_ST_LINE);
  endfunction
endpackage

// File: rtl/mem_line_responder_if.sv
// Request/response bundle between the core miss path (master) and the memory responder (slave).
interface mem_line_responder_if;
  import mem_rsp_pkg::*;

  logic              mem_req_valid;
  logic [63:0]       mem_req_addr;
  logic [3:0]        mem_req_opcode;
  logic [LINE_W-1:0] mem_req_store_data;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_load_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    input  mem_rsp_valid, mem_rsp_load_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_opcode, mem_req_store_data,
    output mem_rsp_valid, mem_rsp_load_data
  );
endinterface

// File: rtl/mem_rsp_ram.sv
// Single-port 2^AW x 128 synchronous line RAM (1-cycle read), block-RAM inferable.
module mem_rsp_ram
  import mem_rsp_pkg::*;
#(
  parameter int    AW        = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) ram[addr] <= wdata;
      else    rdata     <= ram[addr];
    end
  end
endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency line load/store responder backed by on-chip RAM.
// Optional feature macro: MEM_RSP_JITTER_EN adds 0..7 LFSR-chosen cycles of latency per request.
module mem_line_responder
  import mem_rsp_pkg::*;
#(
  parameter int    LINE_AW   = 16,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_line_responder_if.slave  mem,
  output logic                 busy,
  output logic                 bad_addr,
  output logic                 bad_opcode
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_load_q, rsp_load_d;
  logic               bad_addr_q, bad_addr_d;
  logic               bad_opcode_q, bad_opcode_d;
  logic [LINE_AW-1:0] line_q, line_d;
  logic [3:0]         op_q, op_d;
  logic               oor_q, oor_d;
  logic [LINE_W-1:0]  data_q, data_d;

  logic               capture, last_wait, req_oor;
  logic               ram_en, ram_we;
  logic [LINE_W-1:0]  ram_rdata;
  logic [CNT_W-1:0]   lat_init;
  logic               unused_addr_lo;

  assign capture        = (state_q == IDLE) && mem.mem_req_valid;
  assign last_wait      = (state_q == WAIT) && (cnt_q == '0);
  assign req_oor        = |mem.mem_req_addr[63:LINE_AW+4];
  assign unused_addr_lo = ^mem.mem_req_addr[3:0];

`ifdef MEM_RSP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11; free-running so the extra delay is decorrelated from request timing
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lat_init = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign lat_init = CNT_W'(LATENCY - 1);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_load_d   = rsp_load_q;
    bad_addr_d   = bad_addr_q;
    bad_opcode_d = bad_opcode_q;
    case (state_q)
      IDLE: begin
        if (mem.mem_req_valid) begin
          state_d      = WAIT;
          cnt_d        = lat_init;
          bad_addr_d   = bad_addr_q | req_oor;
          bad_opcode_d = bad_opcode_q | !op_legal(mem.mem_req_opcode);
        end
      end
      // Counter starts at LATENCY-1 and is tested before decrement, so WAIT spans LATENCY edges
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_load_d  = (op_q == MEM_LD_LINE) && !oor_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_load_q   <= 1'b0;
      bad_addr_q   <= 1'b0;
      bad_opcode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_load_q   <= rsp_load_d;
      bad_addr_q   <= bad_addr_d;
      bad_opcode_q <= bad_opcode_d;
    end
  end

  // Request capture: datapath only, qualified by the FSM so no reset is needed
  always_comb begin
    line_d = line_q;
    op_d   = op_q;
    oor_d  = oor_q;
    data_d = data_q;
    if (capture) begin
      line_d = mem.mem_req_addr[LINE_AW+3:4];
      op_d   = mem.mem_req_opcode;
      oor_d  = req_oor;
      data_d = mem.mem_req_store_data;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
    op_q   <= op_d;
    oor_q  <= oor_d;
    data_q <= data_d;
  end

  // RAM is touched only in the last WAIT cycle; a reset before then leaves it untouched
  assign ram_en = last_wait && !oor_q && op_legal(op_q);
  assign ram_we = last_wait && !oor_q && (op_q == MEM_ST_LINE);

  mem_rsp_ram #(
    .AW        (LINE_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (line_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  assign mem.mem_rsp_valid     = rsp_valid_q;
  assign mem.mem_rsp_load_data = (rsp_valid_q && rsp_load_q) ? ram_rdata : '0;
  assign busy                  = (state_q != IDLE);
  assign bad_addr              = bad_addr_q;
  assign bad_opcode            = bad_opcode_q;
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: LATENCY 4 (main), 1 and 255 instances.
module tb_mem_line_responder;
  import mem_rsp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [2:0]        vld;
  logic [63:0]       req_addr;
  logic [3:0]        req_op;
  logic [127:0]      req_data;
  logic [2:0]        rv, busy, bada, bado;
  logic [127:0]      rdv [3];

  mem_line_responder_if if0 ();
  mem_line_responder_if if1 ();
  mem_line_responder_if if2 ();

  assign if0.mem_req_valid = vld[0];
  assign if1.mem_req_valid = vld[1];
  assign if2.mem_req_valid = vld[2];
  assign if0.mem_req_addr = req_addr;  assign if0.mem_req_opcode = req_op;  assign if0.mem_req_store_data = req_data;
  assign if1.mem_req_addr = req_addr;  assign if1.mem_req_opcode = req_op;  assign if1.mem_req_store_data = req_data;
  assign if2.mem_req_addr = req_addr;  assign if2.mem_req_opcode = req_op;  assign if2.mem_req_store_data = req_data;
  assign rv     = {if2.mem_rsp_valid, if1.mem_rsp_valid, if0.mem_rsp_valid};
  assign rdv[0] = if0.mem_rsp_load_data;
  assign rdv[1] = if1.mem_rsp_load_data;
  assign rdv[2] = if2.mem_rsp_load_data;

  mem_line_responder #(.LINE_AW(16), .LATENCY(4)) dut0 (
    .clk(clk), .reset(reset), .mem(if0.slave), .busy(busy[0]), .bad_addr(bada[0]), .bad_opcode(bado[0]));
  mem_line_responder #(.LINE_AW(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem(if1.slave), .busy(busy[1]), .bad_addr(bada[1]), .bad_opcode(bado[1]));
  mem_line_responder #(.LINE_AW(4), .LATENCY(255)) dut2 (
    .clk(clk), .reset(reset), .mem(if2.slave), .busy(busy[2]), .bad_addr(bada[2]), .bad_opcode(bado[2]));

  int checks = 0;
  int failures = 0;
  int lat_exp [3] = '{4, 1, 255};

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D4 = 128'h13579BDF2468ACE0FFFF0000FFFF0000;

  typedef struct {
    logic [3:0]   op;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_data;
    logic         exp_ba;
    logic         exp_bo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request on instance w; returns ack latency (edges after capture) and ack data.
  task automatic run_req(input int w, input logic [3:0] op, input logic [63:0] addr,
                         input logic [127:0] data, input bit mangle,
                         output int lat, output logic [127:0] rd);
    bit got;
    @(negedge clk);
    req_op = op; req_addr = addr; req_data = data; vld[w] = 1'b1;
    @(posedge clk); #1;
    if (mangle) begin
      req_addr = ~addr; req_op = 4'd2; req_data = ~data; vld[w] = 1'b0;
    end
    got = 1'b0; lat = -1; rd = '0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk($sformatf("i%0d_busy_inflight", w), busy[w], 1'b1);
      if (rv[w]) begin
        got = 1'b1; lat = k; rd = rdv[w];
      end
    end
    vld[w] = 1'b0;
    chk($sformatf("i%0d_ack_seen", w), got, 1'b1);
`ifdef MEM_RSP_JITTER_EN
    chk($sformatf("i%0d_lat_range(%0d)", w, lat), (lat >= lat_exp[w]) && (lat <= lat_exp[w] + 7), 1'b1);
`else
    chk($sformatf("i%0d_latency", w), lat, lat_exp[w]);
`endif
    @(posedge clk); #1;
    chk($sformatf("i%0d_rsp_one_cycle", w), rv[w], 1'b0);
    @(posedge clk); #1;
    chk($sformatf("i%0d_idle_after_hold", w), busy[w], 1'b0);
  endtask

  initial begin
    int           lat;
    logic [127:0] rd;

    vecs[0]  = '{MEM_ST_LINE, 64'h1000,        D1,  128'h0, 1'b0, 1'b0};
    vecs[1]  = '{MEM_LD_LINE, 64'h1000,        '0,  D1,     1'b0, 1'b0};
    vecs[2]  = '{MEM_ST_LINE, 64'h2008,        D2,  128'h0, 1'b0, 1'b0};
    vecs[3]  = '{MEM_LD_LINE, 64'h200C,        '0,  D2,     1'b0, 1'b0};
    vecs[4]  = '{MEM_LD_LINE, 64'h1_0000_0000, '0,  128'h0, 1'b1, 1'b0};
    vecs[5]  = '{MEM_LD_LINE, 64'h1000,        '0,  D1,     1'b1, 1'b0};
    vecs[6]  = '{MEM_ST_LINE, 64'h1_0000_1000, D3,  128'h0, 1'b1, 1'b0};
    vecs[7]  = '{MEM_LD_LINE, 64'h1000,        '0,  D1,     1'b1, 1'b0};
    vecs[8]  = '{4'd2,        64'h1000,        D3,  128'h0, 1'b1, 1'b1};
    vecs[9]  = '{MEM_LD_LINE, 64'h1000,        '0,  D1,     1'b1, 1'b1};
    vecs[10] = '{MEM_ST_LINE, 64'h1000,        D3,  128'h0, 1'b1, 1'b1};
    vecs[11] = '{MEM_LD_LINE, 64'h1000,        '0,  D3,     1'b1, 1'b1};

    reset = 1'b0; vld = '0; req_addr = '0; req_op = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rv, 3'b000);
    chk("reset_busy",      busy, 3'b000);
    chk("reset_bad_addr",  bada, 3'b000);
    chk("reset_bad_op",    bado, 3'b000);
    chk("reset_rsp_data",  rdv[0], 128'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_req(0, vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0, lat, rd);
      chk($sformatf("v%0d_data", i),     rd,      vecs[i].exp_data);
      chk($sformatf("v%0d_bad_addr", i), bada[0], vecs[i].exp_ba);
      chk($sformatf("v%0d_bad_op", i),   bado[0], vecs[i].exp_bo);
    end

    // Reset in the middle of a store's WAIT: outputs drop at once and the store never lands
    @(negedge clk);
    req_op = MEM_ST_LINE; req_addr = 64'h1000; req_data = D4; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("midstore_busy", busy[0], 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy",     busy[0], 1'b0);
    chk("async_rst_valid",    rv[0],   1'b0);
    chk("async_rst_bad_addr", bada[0], 1'b0);
    chk("async_rst_bad_op",   bado[0], 1'b0);
    chk("async_rst_data",     rdv[0],  128'h0);
    @(negedge clk);
    reset = 1'b1;
    run_req(0, MEM_LD_LINE, 64'h1000, '0, 1'b0, lat, rd);
    chk("after_rst_old_data", rd, D3);

    // Request inputs scrambled and valid dropped right after capture
    run_req(0, MEM_LD_LINE, 64'h2000, '0, 1'b1, lat, rd);
    chk("mangle_data",     rd,      D2);
    chk("mangle_bad_addr", bada[0], 1'b0);
    chk("mangle_bad_op",   bado[0], 1'b0);

    // Latency extremes
    run_req(1, MEM_ST_LINE, 64'h10, D1, 1'b0, lat, rd);
    chk("l1_store_data", rd, 128'h0);
    run_req(1, MEM_LD_LINE, 64'h10, '0, 1'b0, lat, rd);
    chk("l1_load_data", rd, D1);
    run_req(2, MEM_ST_LINE, 64'h20, D2, 1'b0, lat, rd);
    chk("l255_store_data", rd, 128'h0);
    run_req(2, MEM_LD_LINE, 64'h20, '0, 1'b0, lat, rd);
    chk("l255_load_data", rd, D2);

`ifdef MEM_RSP_JITTER_EN
    begin
      bit [7:0] seen;
      seen = '0;
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run_req(0, MEM_LD_LINE, 64'h2000, '0, 1'b0, lat, rd);
        if (lat >= 4 && lat <= 11) seen[lat - 4] = 1'b1;
      end
      chk("jitter_all_values", seen, 8'hFF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
